// File: rtl/vx_axi_req_relocator.sv
// vx_axi_req_relocator: AW/AR request relocation stage for the Vortex AXI master.
// Each address channel has a 2-entry FIFO skid buffer. The buffer adds the programmed
// base offset to the address when a request is captured. Issue to the interconnect is
// gated by an outstanding-burst cap. A freeze/quiesce handshake lets the core be
// drained safely before a soft reset.
// Optional: define VX_AXI_RELOC_WINDOW_CHECK_EN to add the limit input and the sticky
// win_err output for address-window checking.
module vx_axi_req_relocator #(
  parameter int unsigned ID_W            = 8,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              base_we,
  input  logic [ADDR_W-1:0] base_wdata,
  output logic [ADDR_W-1:0] base_q,
  input  logic              freeze,
  output logic              quiesced,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_awvalid,
  output logic              s_awready,
  output logic [ID_W-1:0]   m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              mon_bvalid,
  input  logic              mon_bready,
  input  logic              mon_rvalid,
  input  logic              mon_rready,
  input  logic              mon_rlast,
  output logic [CntW-1:0]   wr_outstanding,
  output logic [CntW-1:0]   rd_outstanding,
`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
  input  logic [ADDR_W-1:0] limit,
  output logic              win_err,
`endif
  output logic              cnt_err
);

  localparam int unsigned NumCh = 2;  // index 0 = write (AW), 1 = read (AR)
  localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } req_t;

  req_t [NumCh-1:0]           s_req;
  req_t [NumCh-1:0]           m_req;
  logic [NumCh-1:0]           s_valid, s_rdy, m_valid, m_ready, dec, uflow, empty;
  logic [NumCh-1:0][CntW-1:0] out_cnt;

  logic [ADDR_W-1:0] base_d;
  logic              cnt_err_d, quiesced_d;

  assign s_req[0] = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst};
  assign s_req[1] = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
  assign s_valid  = {s_arvalid, s_awvalid};
  assign m_ready  = {m_arready, m_awready};
  assign dec[0]   = mon_bvalid & mon_bready;
  assign dec[1]   = mon_rvalid & mon_rready & mon_rlast;

  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst} = m_req[0];
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst} = m_req[1];
  assign m_awvalid      = m_valid[0];
  assign m_arvalid      = m_valid[1];
  assign s_awready      = s_rdy[0];
  assign s_arready      = s_rdy[1];
  assign wr_outstanding = out_cnt[0];
  assign rd_outstanding = out_cnt[1];

`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
  logic [NumCh-1:0] win_hit;
  logic             win_err_d;
`endif

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    req_t [1:0]      mem_q, mem_d;
    req_t            cap;
    logic            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]      fill_q, fill_d;
    logic            rdy_q, rdy_d, hold_q, hold_d;
    logic [CntW-1:0] out_q, out_d;
    logic            push, pop, ch_uflow;

    // Once issued, hold_q keeps valid up independent of the cap until accepted.
    assign push       = s_valid[c] & rdy_q;
    assign m_valid[c] = (fill_q != 2'd0) & (hold_q | (out_q < MaxOut));
    assign pop        = m_valid[c] & m_ready[c];
    assign m_req[c]   = mem_q[rptr_q];
    assign s_rdy[c]   = rdy_q;
    assign out_cnt[c] = out_q;
    assign uflow[c]   = ch_uflow;
    assign empty[c]   = (fill_q == 2'd0);

    // Next state for the skid FIFO, ready flag and outstanding counter.
    always_comb begin
      cap      = s_req[c];
      cap.addr = s_req[c].addr + base_q;
      mem_d    = mem_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      if (push) begin
        mem_d[wptr_q] = cap;
        wptr_d        = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      fill_d   = fill_q + {1'b0, push} - {1'b0, pop};
      rdy_d    = (fill_d != 2'd2) & ~freeze;
      hold_d   = m_valid[c] & ~m_ready[c];
      out_d    = out_q;
      ch_uflow = 1'b0;
      if (pop && !dec[c]) begin
        out_d = out_q + CntW'(1);
      end else if (dec[c] && !pop) begin
        if (out_q == '0) begin
          ch_uflow = 1'b1;
        end else begin
          out_d = out_q - CntW'(1);
        end
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        mem_q  <= '0;
        wptr_q <= 1'b0;
        rptr_q <= 1'b0;
        fill_q <= 2'd0;
        rdy_q  <= 1'b1;
        hold_q <= 1'b0;
        out_q  <= '0;
      end else begin
        mem_q  <= mem_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        fill_q <= fill_d;
        rdy_q  <= rdy_d;
        hold_q <= hold_d;
        out_q  <= out_d;
      end
    end

`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
    logic [15:0]     span_bytes;
    logic [ADDR_W:0] span_end, win_bound;

    // Last byte of the burst against the top of the window, one bit wider to avoid wrap.
    always_comb begin
      span_bytes = (16'(s_req[c].len) + 16'd1) << s_req[c].size;
      span_end   = {1'b0, cap.addr} + (ADDR_W + 1)'(span_bytes) - (ADDR_W + 1)'(1);
      win_bound  = {1'b0, base_q} + {1'b0, limit};
      win_hit[c] = push & (span_end > win_bound);
    end
`endif
  end

  // Shared next state: base offset, sticky underflow and quiesce status.
  always_comb begin
    base_d     = base_we ? base_wdata : base_q;
    cnt_err_d  = cnt_err | (|uflow);
    quiesced_d = freeze & (&empty) & (out_cnt[0] == '0) & (out_cnt[1] == '0);
  end

  // Shared registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q   <= '0;
      cnt_err  <= 1'b0;
      quiesced <= 1'b0;
    end else begin
      base_q   <= base_d;
      cnt_err  <= cnt_err_d;
      quiesced <= quiesced_d;
    end
  end

`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
  // Sticky window violation; a base reprogram starts a fresh window.
  always_comb begin
    win_err_d = (win_err & ~base_we) | (|win_hit);
  end

  // Window error register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_err <= 1'b0;
    end else begin
      win_err <= win_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_vx_axi_req_relocator.sv
// Directed bench for vx_axi_req_relocator: table of single relocations plus corner sequences.
module tb_vx_axi_req_relocator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        base_we = 1'b0;
  logic [31:0] base_wdata = '0;
  logic [31:0] base_q;
  logic        freeze = 1'b0;
  logic        quiesced;
  logic [7:0]  s_awid = '0, s_arid = '0, m_awid, m_arid;
  logic [31:0] s_awaddr = '0, s_araddr = '0, m_awaddr, m_araddr;
  logic [7:0]  s_awlen = '0, s_arlen = '0, m_awlen, m_arlen;
  logic [2:0]  s_awsize = '0, s_arsize = '0, m_awsize, m_arsize;
  logic [1:0]  s_awburst = '0, s_arburst = '0, m_awburst, m_arburst;
  logic        s_awvalid = 1'b0, s_arvalid = 1'b0, s_awready, s_arready;
  logic        m_awvalid, m_arvalid;
  logic        m_awready = 1'b0, m_arready = 1'b0;
  logic        mon_bvalid = 1'b0, mon_bready = 1'b0;
  logic        mon_rvalid = 1'b0, mon_rready = 1'b0, mon_rlast = 1'b0;
  logic [4:0]  wr_outstanding, rd_outstanding;
  logic        cnt_err;
`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
  logic [31:0] limit = 32'hFFFF_FFFF;
  logic        win_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  vx_axi_req_relocator #(.ID_W(8), .ADDR_W(32), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .rstn(rstn), .base_we(base_we), .base_wdata(base_wdata), .base_q(base_q),
    .freeze(freeze), .quiesced(quiesced),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
`ifdef VX_AXI_RELOC_WINDOW_CHECK_EN
    .limit(limit), .win_err(win_err),
`endif
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ch;  // 0 = AW, 1 = AR
    logic [31:0] base;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic set_base(input logic [31:0] b);
    base_we    = 1'b1;
    base_wdata = b;
    tick();
    base_we    = 1'b0;
  endtask

  // Present one request and hold it until the handshake edge (bounded wait).
  task automatic send(input logic ch, input logic [31:0] a, input logic [7:0] l,
                      input logic [7:0] id);
    int n;
    n = 0;
    if (ch) begin
      s_arid = id; s_araddr = a; s_arlen = l; s_arsize = 3'd2; s_arburst = 2'b01;
      s_arvalid = 1'b1;
    end else begin
      s_awid = id; s_awaddr = a; s_awlen = l; s_awsize = 3'd2; s_awburst = 2'b01;
      s_awvalid = 1'b1;
    end
    while (!(ch ? s_arready : s_awready) && n < 50) begin
      tick();
      n++;
    end
    check("send_accept", 64'(ch ? s_arready : s_awready), 64'd1);
    tick();
    s_awvalid = 1'b0;
    s_arvalid = 1'b0;
  endtask

  // One B handshake (ch 0) or one R-last handshake (ch 1).
  task automatic resp(input logic ch);
    if (ch) begin
      mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rlast = 1'b1;
    end else begin
      mon_bvalid = 1'b1; mon_bready = 1'b1;
    end
    tick();
    mon_rvalid = 1'b0; mon_rready = 1'b0; mon_rlast = 1'b0;
    mon_bvalid = 1'b0; mon_bready = 1'b0;
  endtask

  initial begin
    int issued, accepted;
    vecs[0] = '{1'b0, 32'h8000_0000, 32'h0000_0100, 8'd3, 32'h8000_0100};
    vecs[1] = '{1'b1, 32'hFFFF_FF00, 32'h0000_0200, 8'd0, 32'h0000_0100};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_1234, 8'd7, 32'h0000_1234};
    vecs[3] = '{1'b1, 32'h0000_1000, 32'hFFFF_F000, 8'd1, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 8'd0, 32'h2345_6789};

    // Reset state
    tick();
    check("rst_base", 64'(base_q), 64'd0);
    check("rst_mawvalid", 64'(m_awvalid), 64'd0);
    check("rst_marvalid", 64'(m_arvalid), 64'd0);
    check("rst_sawready", 64'(s_awready), 64'd1);
    check("rst_sarready", 64'(s_arready), 64'd1);
    check("rst_wr_cnt", 64'(wr_outstanding), 64'd0);
    check("rst_rd_cnt", 64'(rd_outstanding), 64'd0);
    check("rst_cnt_err", 64'(cnt_err), 64'd0);
    check("rst_quiesced", 64'(quiesced), 64'd0);
    rstn = 1'b1;
    tick();

    // Table: program base, send one request, check relocation, issue, retire
    for (int i = 0; i < 5; i++) begin
      set_base(vecs[i].base);
      check("vec_base_q", 64'(base_q), 64'(vecs[i].base));
      send(vecs[i].ch, vecs[i].addr, vecs[i].len, 8'(i + 1));
      check("vec_mvalid", 64'(vecs[i].ch ? m_arvalid : m_awvalid), 64'd1);
      check("vec_maddr", 64'(vecs[i].ch ? m_araddr : m_awaddr), 64'(vecs[i].exp_addr));
      check("vec_mlen", 64'(vecs[i].ch ? m_arlen : m_awlen), 64'(vecs[i].len));
      check("vec_mid", 64'(vecs[i].ch ? m_arid : m_awid), 64'(i + 1));
      if (vecs[i].ch) m_arready = 1'b1; else m_awready = 1'b1;
      tick();
      m_arready = 1'b0;
      m_awready = 1'b0;
      check("vec_issue_cnt", 64'(vecs[i].ch ? rd_outstanding : wr_outstanding), 64'd1);
      check("vec_mvalid_low", 64'(vecs[i].ch ? m_arvalid : m_awvalid), 64'd0);
      resp(vecs[i].ch);
      check("vec_retire_cnt", 64'(vecs[i].ch ? rd_outstanding : wr_outstanding), 64'd0);
    end

    // Multi-beat read: only the rlast beat retires the burst
    set_base(32'hFFFF_FF00);
    send(1'b1, 32'h0000_0200, 8'd3, 8'h33);
    check("rb_addr_wrap", 64'(m_araddr), 64'h0000_0100);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mon_rvalid = 1'b1; mon_rready = 1'b1; mon_rlast = 1'b0;
      tick();
      check("rb_nonlast_beat", 64'(rd_outstanding), 64'd1);
    end
    mon_rlast = 1'b1;
    tick();
    mon_rvalid = 1'b0; mon_rready = 1'b0; mon_rlast = 1'b0;
    check("rb_last_beat", 64'(rd_outstanding), 64'd0);

    // Outstanding cap: 20 back-to-back reads with no responses
    issued = 0;
    accepted = 0;
    m_arready = 1'b1;
    s_arvalid = 1'b1;
    s_araddr = 32'h40;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (m_arvalid && m_arready) issued++;
      if (s_arvalid && s_arready) accepted++;
      if (accepted >= 20) s_arvalid = 1'b0;
      tick();
    end
    s_arvalid = 1'b0;
    check("cap_issued", 64'(issued), 64'd16);
    check("cap_accepted", 64'(accepted), 64'd18);
    check("cap_rd_cnt", 64'(rd_outstanding), 64'd16);
    check("cap_marvalid_low", 64'(m_arvalid), 64'd0);
    check("cap_sarready_low", 64'(s_arready), 64'd0);
    resp(1'b1);
    check("cap_17th_valid", 64'(m_arvalid), 64'd1);
    tick();
    check("cap_17th_issued", 64'(rd_outstanding), 64'd16);
    check("cap_recapped", 64'(m_arvalid), 64'd0);

    // Reset mid-burst clears at once; a late response at count 0 is an underflow
    rstn = 1'b0;
    #1;
    check("midrst_rd_cnt", 64'(rd_outstanding), 64'd0);
    check("midrst_marvalid", 64'(m_arvalid), 64'd0);
    tick();
    rstn = 1'b1;
    m_arready = 1'b0;
    resp(1'b1);
    check("late_r_cnt", 64'(rd_outstanding), 64'd0);
    check("late_r_err", 64'(cnt_err), 64'd1);
    do_reset();

    // Simultaneous issue and retire at count 5, then underflow at 0
    m_awready = 1'b1;
    for (int k = 0; k < 5; k++) send(1'b0, 32'(k * 16), 8'd0, 8'(k));
    tick();
    tick();
    check("sim_pre_cnt", 64'(wr_outstanding), 64'd5);
    m_awready = 1'b0;
    send(1'b0, 32'h500, 8'd0, 8'h55);
    m_awready = 1'b1; mon_bvalid = 1'b1; mon_bready = 1'b1;
    tick();
    m_awready = 1'b0; mon_bvalid = 1'b0; mon_bready = 1'b0;
    check("sim_same_cycle", 64'(wr_outstanding), 64'd5);
    for (int k = 0; k < 5; k++) resp(1'b0);
    check("sim_drained", 64'(wr_outstanding), 64'd0);
    check("sim_no_err_yet", 64'(cnt_err), 64'd0);
    resp(1'b0);
    check("uflow_cnt", 64'(wr_outstanding), 64'd0);
    check("uflow_err", 64'(cnt_err), 64'd1);
    tick();
    check("uflow_sticky", 64'(cnt_err), 64'd1);
    do_reset();
    check("uflow_cleared", 64'(cnt_err), 64'd0);

    // Freeze with 3 outstanding writes and 2 buffered reads
    m_awready = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b0, 32'h1000, 8'd0, 8'(k));
    tick();
    tick();
    m_awready = 1'b0;
    check("frz_wr_cnt", 64'(wr_outstanding), 64'd3);
    send(1'b1, 32'h2000, 8'd0, 8'h1);
    send(1'b1, 32'h3000, 8'd0, 8'h2);
    freeze = 1'b1;
    tick();
    check("frz_sawready", 64'(s_awready), 64'd0);
    check("frz_sarready", 64'(s_arready), 64'd0);
    check("frz_not_quiet", 64'(quiesced), 64'd0);
    m_arready = 1'b1;
    tick();
    check("frz_ar1_addr", 64'(m_araddr), 64'h3000);
    tick();
    m_arready = 1'b0;
    check("frz_rd_cnt", 64'(rd_outstanding), 64'd2);
    check("frz_drained", 64'(m_arvalid), 64'd0);
    for (int k = 0; k < 3; k++) resp(1'b0);
    resp(1'b1);
    resp(1'b1);
    check("frz_q_lag", 64'(quiesced), 64'd0);
    tick();
    check("frz_q_rise", 64'(quiesced), 64'd1);
    freeze = 1'b0;
    tick();
    check("unfrz_sawready", 64'(s_awready), 64'd1);
    check("unfrz_sarready", 64'(s_arready), 64'd1);
    check("unfrz_q_low", 64'(quiesced), 64'd0);

    // Base change while an AW is stalled
    set_base(32'h0000_1000);
    send(1'b0, 32'h20, 8'd0, 8'hA);
    check("stall_addr", 64'(m_awaddr), 64'h1020);
    set_base(32'h0000_5000);
    check("stall_hold_addr", 64'(m_awaddr), 64'h1020);
    check("stall_hold_valid", 64'(m_awvalid), 64'd1);
    send(1'b0, 32'h40, 8'd0, 8'hB);
    check("stall_still_addr", 64'(m_awaddr), 64'h1020);
    m_awready = 1'b1;
    tick();
    check("newbase_addr", 64'(m_awaddr), 64'h5040);
    check("newbase_id", 64'(m_awid), 64'hB);
    tick();
    m_awready = 1'b0;
    check("newbase_cnt", 64'(wr_outstanding), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_axi_req_relocator.md
Name: vx_axi_req_relocator

Overview:
- Downstream stage on the Vortex AXI master's request path, between the Vortex core AXI port and the SoC AXI interconnect.
- Buffers the AW and AR address channels in registered 2-entry skid buffers and adds a software-programmed base offset to each address at capture.
- Tracks outstanding write and read bursts and caps them at a limit.
- Provides a freeze/quiesce handshake so the soft-reset controller can drain traffic safely before resetting the core.
- W, B and R channels bypass this block; B and R are only monitored.

Parameters:
- ID_W, 8, AXI ID width.
- ADDR_W, 32, AXI address width.
- MAX_OUTSTANDING, 16, maximum in-flight bursts per direction (write and read counted separately).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- base_we  in  1  base offset write strobe
- base_wdata  in  ADDR_W  new base offset
- base_q  out  ADDR_W  current base offset
- freeze  in  1  stop accepting new requests
- quiesced  out  1  frozen and fully drained
- s_aw{id,addr,len,size,burst,valid}  in  ID_W/ADDR_W/8/3/2/1  upstream AW request
- s_awready  out  1  upstream AW ready
- m_aw{id,addr,len,size,burst,valid}  out  ID_W/ADDR_W/8/3/2/1  downstream AW request
- m_awready  in  1  downstream AW ready
- s_ar*/s_arready, m_ar*/m_arready  same shape as AW  read address channel
- mon_bvalid, mon_bready  in  1 each  observed B handshake
- mon_rvalid, mon_rready, mon_rlast  in  1 each  observed R handshake
- wr_outstanding, rd_outstanding  out  $clog2(MAX_OUTSTANDING+1) each  in-flight burst counts
- cnt_err  out  1  sticky counter underflow flag

Behaviour:
- Reset (rstn low, asynchronous):
  - base_q = 0; all skid buffers empty.
  - m_awvalid = m_arvalid = 0; s_awready = s_arready = 1.
  - Both counters = 0; cnt_err = 0; quiesced = 0.
- Base register:
  - base_we loads base_wdata on the next edge.
  - The new base applies only to requests captured after that edge.
  - Captured entries keep the address computed at capture, so m_*addr never changes while m_*valid is high.
- Capture:
  - On s_*valid & s_*ready, store {id, addr+base_q mod 2^ADDR_W, len, size, burst}.
  - Address addition wraps; no carry out.
- Skid buffer, per channel, 2 entries:
  - s_*ready = !full & !freeze, registered.
  - Latency 1 cycle from the s-side handshake to m_*valid.
  - One transfer per cycle sustained while downstream stays ready.
  - Ordering is FIFO.
- Issue gating:
  - m_awvalid = head_valid & (wr_outstanding < MAX_OUTSTANDING), evaluated only while not already asserted.
  - Once asserted, m_*valid and its payload hold until m_*ready.
  - Same rule for AR with rd_outstanding.
- Write counter:
  - +1 on m_awvalid & m_awready; -1 on mon_bvalid & mon_bready.
  - Both in the same cycle: unchanged.
- Read counter:
  - +1 on the AR handshake; -1 on mon_rvalid & mon_rready & mon_rlast.
  - Non-last beats are ignored.
- Underflow: a decrement at count 0 leaves the count at 0 and sets cnt_err; cnt_err clears only on reset.
- Freeze:
  - freeze=1 deasserts s_*ready on the next edge.
  - Buffered entries continue to drain.
  - quiesced = freeze & both buffers empty & both counters 0, registered (1 cycle after the condition holds).
  - freeze=0 clears quiesced and re-enables s_*ready the next cycle.
- Reset mid-burst: everything clears immediately; in-flight responses arriving after reset count as underflow only if a counter is 0.

Optional Feature:
- Macro: VX_AXI_RELOC_WINDOW_CHECK_EN
- When defined:
  - Adds input limit (ADDR_W) and output win_err (1, sticky).
  - Any captured request whose relocated address + (len+1)*2^size - 1 exceeds base_q + limit sets win_err.
  - The request is still forwarded unchanged.
  - win_err clears on reset or on base_we.
- When undefined: no limit/win_err ports and no comparator logic.

Test Plan:
- base_we with 0x8000_0000; single AW addr 0x100 len 3 -> m_awaddr 0x8000_0100 one cycle after the handshake; wr_outstanding 1; then one B handshake -> 0.
- base 0xFFFF_FF00, AR addr 0x200 -> m_araddr 0x0000_0100 (wrap); 4-beat R with rlast on beat 4 -> rd_outstanding decrements only after beat 4.
- MAX_OUTSTANDING=16, m_arready=1, no R responses, 20 back-to-back ARs -> exactly 16 issued, m_arvalid low, s_arready low once the buffer is full; one R-last -> 17th issues next cycle.
- Simultaneous AW handshake and B handshake at count 5 -> count stays 5; B handshake at count 0 -> count 0, cnt_err=1.
- freeze with 2 buffered ARs and 3 outstanding writes -> s_*ready=0 next cycle, buffered ARs issue, quiesced rises 1 cycle after the last B/R-last; freeze=0 -> s_*ready=1 next cycle.
- Base change while an AW is stalled (m_awready=0) -> stalled m_awaddr unchanged; the next capture uses the new base.
